pwm_ramp_ctrl: RTL

//   Avalon-MM-configured sequencer that drives the duty and direction inputs of the PWM

---
 rtl/pwm_ramp_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: Avalon-MM configured duty/direction sequencer in front of pwm_gen.
// Ramps duty toward a software target per tick; reversals go brake -> dead time -> flip -> ramp.
module pwm_ramp_ctrl #(
  parameter int DUTY_W     = 8,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_TICKS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              estop_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              dir_o,
  output logic              pwm_en_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
  localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
  localparam logic [DEAD_W-1:0] DEAD_ZERO = {DEAD_W{1'b0}};

  // One saturating step from cur toward tgt, done one bit wider so it cannot wrap.
  function automatic logic [DUTY_W-1:0] ramp_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W:0]   wide;
    logic [DUTY_W-1:0] res;
    if (cur < tgt) begin
      wide = {1'b0, cur} + {1'b0, step};
      res  = (wide > {1'b0, tgt}) ? tgt : wide[DUTY_W-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, step};
      res  = (wide[DUTY_W] || (wide[DUTY_W-1:0] < tgt)) ? tgt : wide[DUTY_W-1:0];
    end
    return res;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [PRE_W-1:0]  presc_r;
  logic [DEAD_W-1:0] dead_cnt_r, dead_nxt_s;
  logic [DUTY_W-1:0] duty_r, duty_nxt_s, target_r, step_r, step_eff_s, eff_tgt_s;
  logic              enable_r, dir_req_r, dir_r, pwm_en_r, busy_r;
  logic              dir_nxt_s, pwm_en_nxt_s, tick_s;
  logic [31:0]       readdata_r, rd_mux_s;
  logic [7:0]        duty_status_s;
  logic              unused_wdata_s;

  assign tick_s         = (presc_r == PRE_W'(TICK_DIV - 1));
  assign step_eff_s     = (step_r == DUTY_ZERO) ? DUTY_W'(1'b1) : step_r;
  assign eff_tgt_s      = (enable_r && !estop_i) ? target_r : DUTY_ZERO;
  assign duty_status_s  = 8'(duty_r);
  assign unused_wdata_s = &{1'b0, avs_writedata[31:DUTY_W]};

  // Free-running ramp tick prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PRE_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRE_W'(1'b1);
    end
  end

  // Software registers; estop clears enable even against a simultaneous CTRL write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_r  <= 1'b0;
      dir_req_r <= 1'b0;
      target_r  <= DUTY_ZERO;
      step_r    <= DUTY_ZERO;
    end else begin
      if (avs_write && (avs_address == 2'd0)) begin
        enable_r  <= avs_writedata[0] & ~estop_i;
        dir_req_r <= avs_writedata[1];
      end else if (estop_i) begin
        enable_r  <= 1'b0;
      end
      if (avs_write && (avs_address == 2'd1)) begin
        target_r <= avs_writedata[DUTY_W-1:0];
      end
      if (avs_write && (avs_address == 2'd2)) begin
        step_r <= avs_writedata[DUTY_W-1:0];
      end
    end
  end

  // Read mux
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      2'd0:    rd_mux_s = {30'd0, dir_req_r, enable_r};
      2'd1:    rd_mux_s = 32'(target_r);
      2'd2:    rd_mux_s = 32'(step_r);
      2'd3:    rd_mux_s = {16'd0, duty_status_s, 3'd0, pwm_en_r, dir_r, state_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Registered read data, one cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= 32'd0;
    end else if (avs_read) begin
      readdata_r <= rd_mux_s;
    end
  end

  // Next-state and next-output logic; estop overrides every state
  always_comb begin
    state_nxt_s  = state_r;
    duty_nxt_s   = duty_r;
    dir_nxt_s    = dir_r;
    pwm_en_nxt_s = pwm_en_r;
    dead_nxt_s   = dead_cnt_r;
    if (estop_i) begin
      state_nxt_s  = ST_IDLE;
      duty_nxt_s   = DUTY_ZERO;
      pwm_en_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          duty_nxt_s = DUTY_ZERO;
          dir_nxt_s  = dir_req_r;
          if (eff_tgt_s != DUTY_ZERO) begin
            state_nxt_s  = ST_RAMP;
            pwm_en_nxt_s = 1'b1;
          end else begin
            pwm_en_nxt_s = 1'b0;
          end
        end
        ST_RAMP: begin
          if (dir_req_r != dir_r) begin
            state_nxt_s = ST_BRAKE;
          end else if (duty_r == eff_tgt_s) begin
            if (eff_tgt_s == DUTY_ZERO) begin
              state_nxt_s  = ST_IDLE;
              pwm_en_nxt_s = 1'b0;
            end else begin
              state_nxt_s = ST_HOLD;
            end
          end else if (tick_s) begin
            duty_nxt_s = ramp_toward(duty_r, eff_tgt_s, step_eff_s);
          end else begin
            duty_nxt_s = duty_r;
          end
        end
        ST_HOLD: begin
          if (dir_req_r != dir_r) begin
            state_nxt_s = ST_BRAKE;
          end else if (eff_tgt_s != duty_r) begin
            state_nxt_s = ST_RAMP;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_BRAKE: begin
          if (duty_r == DUTY_ZERO) begin
            state_nxt_s = ST_DEAD;
            dead_nxt_s  = DEAD_W'(DEAD_TICKS);
          end else if (dir_req_r == dir_r) begin
            state_nxt_s = ST_RAMP;
          end else if (tick_s) begin
            duty_nxt_s = ramp_toward(duty_r, DUTY_ZERO, step_eff_s);
          end else begin
            duty_nxt_s = duty_r;
          end
        end
        ST_DEAD: begin
          duty_nxt_s = DUTY_ZERO;
          if (dead_cnt_r == DEAD_ZERO) begin
            dir_nxt_s = dir_req_r;
            if (eff_tgt_s != DUTY_ZERO) begin
              state_nxt_s = ST_RAMP;
            end else begin
              state_nxt_s  = ST_IDLE;
              pwm_en_nxt_s = 1'b0;
            end
          end else if (tick_s) begin
            dead_nxt_s = dead_cnt_r - DEAD_W'(1'b1);
          end else begin
            dead_nxt_s = dead_cnt_r;
          end
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          duty_nxt_s   = DUTY_ZERO;
          pwm_en_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      duty_r     <= DUTY_ZERO;
      dir_r      <= 1'b0;
      pwm_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      dead_cnt_r <= DEAD_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      duty_r     <= duty_nxt_s;
      dir_r      <= dir_nxt_s;
      pwm_en_r   <= pwm_en_nxt_s;
      dead_cnt_r <= dead_nxt_s;
      busy_r     <= (state_nxt_s == ST_RAMP) || (state_nxt_s == ST_BRAKE) ||
                    (state_nxt_s == ST_DEAD);
    end
  end

  assign duty_o       = duty_r;
  assign dir_o        = dir_r;
  assign pwm_en_o     = pwm_en_r;
  assign busy_o       = busy_r;
  assign avs_readdata = readdata_r;

endmodule
